// File: rtl/mult_div_unit_pkg.sv
// Shared MDU op encodings and default latencies.
// Imported by mult_div_unit.
package mult_div_unit_pkg;

  localparam int MDOP_W = 4;

  typedef enum logic [MDOP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit writing HI/LO.
// Define MDU_MADD_EN to accept madd/maddu (MDop 7/8).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       A,
  input  logic [31:0]       B,
  input  logic [MDOP_W-1:0] MDop,
  input  logic              start,
  output logic              busy,
  output logic [31:0]       HI,
  output logic [31:0]       LO
);

  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        wr_q, wr_d;
  logic        acc_q, acc_d;
  logic [63:0] tmp_q, tmp_d;
  logic [63:0] hilo_q, hilo_d;

  logic [63:0] sa, sb;
  logic [63:0] prod_s, prod_u;
  logic [31:0] dvs;
  logic [31:0] q_s, r_s, q_u, r_u;

  always_comb begin
    sa     = {{32{A[31]}}, A};
    sb     = {{32{B[31]}}, B};
    prod_s = sa * sb;
    prod_u = {32'd0, A} * {32'd0, B};
    dvs    = (B == 32'd0) ? 32'd1 : B;
    // Dividing by -1 is plain negation; avoids the INT_MIN overflow.
    if (B == '1) begin
      q_s = 32'd0 - A;
      r_s = 32'd0;
    end else begin
      q_s = $signed(A) / $signed(dvs);
      r_s = $signed(A) % $signed(dvs);
    end
    q_u = A / dvs;
    r_u = A % dvs;
  end

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    wr_d   = wr_q;
    acc_d  = acc_q;
    tmp_d  = tmp_q;
    hilo_d = hilo_q;
    if (busy_q) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        if (wr_q)
          hilo_d = acc_q ? hilo_q + tmp_q : tmp_q;
      end
    end else if (start) begin
      case (MDop)
        MD_MULT, MD_MULTU: begin
          tmp_d  = (MDop == MD_MULT) ? prod_s : prod_u;
          cnt_d  = 4'(MULT_CYCLES);
          busy_d = 1'b1;
          wr_d   = 1'b1;
          acc_d  = 1'b0;
        end
        MD_DIV, MD_DIVU: begin
          tmp_d  = (MDop == MD_DIV) ? {r_s, q_s} : {r_u, q_u};
          cnt_d  = 4'(DIV_CYCLES);
          busy_d = 1'b1;
          wr_d   = (B != 32'd0);
          acc_d  = 1'b0;
        end
`ifdef MDU_MADD_EN
        MD_MADD, MD_MADDU: begin
          tmp_d  = (MDop == MD_MADD) ? prod_s : prod_u;
          cnt_d  = 4'(MULT_CYCLES);
          busy_d = 1'b1;
          wr_d   = 1'b1;
          acc_d  = 1'b1;
        end
`endif
        MD_MTHI: hilo_d[63:32] = A;
        MD_MTLO: hilo_d[31:0]  = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
      wr_q   <= 1'b0;
      acc_q  <= 1'b0;
      tmp_q  <= 64'd0;
      hilo_q <= 64'd0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      wr_q   <= wr_d;
      acc_q  <= acc_d;
      tmp_q  <= tmp_d;
      hilo_q <= hilo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hilo_q[63:32];
  assign LO   = hilo_q[31:0];

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// Honours MDU_MADD_EN the same way as the design.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDop;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B),
    .MDop(MDop), .start(start), .busy(busy),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: whole-op semantics with wide integer arithmetic.
  function automatic void model(input logic [3:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                inout logic [63:0] hl,
                                output int cyc);
    longint sa, sb, ua, ub, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    cyc = 0;
    case (op)
      4'd1: begin hl = 64'(sa * sb); cyc = MC; end
      4'd2: begin hl = 64'(ua * ub); cyc = MC; end
      4'd3: begin
        cyc = DC;
        if (b != 0) begin
          q  = sa / sb;
          r  = sa % sb;
          hl = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        cyc = DC;
        if (b != 0) begin
          q  = ua / ub;
          r  = ua % ub;
          hl = {r[31:0], q[31:0]};
        end
      end
      4'd5: hl[63:32] = a;
      4'd6: hl[31:0]  = a;
`ifdef MDU_MADD_EN
      4'd7: begin hl = hl + 64'(sa * sb); cyc = MC; end
      4'd8: begin hl = hl + 64'(ua * ub); cyc = MC; end
`endif
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    MDop = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDop = 4'd0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 40) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=%0d required<40", cyc);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo;
    logic [31:0] exp_hi, exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[10];
  logic [63:0] hl;
  int cyc, ecyc, dummy;
  logic [3:0] rop;
  logic [31:0] ra, rb;

  initial begin
    vecs[0] = '{4'd1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0,
                32'hFFFFFFFF, 32'hFFFFFFFE, MC};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0,
                32'h00000001, 32'hFFFFFFFE, MC};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0,
                32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[3] = '{4'd4, 32'd7, 32'd0, 32'hAAAA5555, 32'h0000BEEF,
                32'hAAAA5555, 32'h0000BEEF, DC};
    vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h2,
                32'h00000000, 32'h80000000, DC};
    vecs[5] = '{4'd4, 32'hFFFFFFFF, 32'd10, 32'h0, 32'h0,
                32'h00000005, 32'h19999999, DC};
    vecs[6] = '{4'd3, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0,
                32'h00000001, 32'hFFFFFFFD, DC};
    vecs[7] = '{4'd3, 32'd0, 32'd0, 32'h13579BDF, 32'h2468ACE0,
                32'h13579BDF, 32'h2468ACE0, DC};
    vecs[8] = '{4'd0, 32'h5, 32'h6, 32'h11, 32'h22,
                32'h11, 32'h22, 0};
    vecs[9] = '{4'd9, 32'h5, 32'h6, 32'h33, 32'h44,
                32'h33, 32'h44, 0};

    reset = 1'b1; start = 1'b0; MDop = 4'd0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(4'd5, vecs[i].pre_hi, 32'd0, dummy);
      run_op(4'd6, vecs[i].pre_lo, 32'd0, dummy);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_hi", i), HI, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), LO, vecs[i].exp_lo);
    end

    // mthi then mtlo on back-to-back edges
    @(negedge clk);
    MDop = 4'd5; A = 32'h12345678; start = 1'b1;
    @(negedge clk);
    check("mthi_hi", HI, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    MDop = 4'd6; A = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0; MDop = 4'd0;
    check("mtlo_lo", LO, 32'h9ABCDEF0);
    check("mtlo_hi_kept", HI, 32'h12345678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    // start while busy must be ignored
    @(negedge clk);
    MDop = 4'd1; A = 32'd3; B = 32'd5; start = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      start = 1'b0; MDop = 4'd0;
      if (!busy) break;
      cyc++;
      if (cyc == 2) begin
        start = 1'b1; MDop = 4'd6; A = 32'hDEADBEEF;
      end
    end
    check("ign_cycles", 32'(cyc), 32'(MC));
    check("ign_lo", LO, 32'd15);
    check("ign_hi", HI, 32'd0);
    @(negedge clk);
    check("ign_busy_after", {31'd0, busy}, 32'd0);

    // reset in the middle of a divide
    MDop = 4'd3; A = 32'd100; B = 32'd7; start = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      start = 1'b0; MDop = 4'd0;
      if (busy) cyc++;
      if (cyc == 3 || !busy) break;
    end
    check("rst_mid_reached", 32'(cyc), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    repeat (DC + 3) @(negedge clk);
    check("rst_late_hi", HI, 32'd0);
    check("rst_late_lo", LO, 32'd0);
    check("rst_late_busy", {31'd0, busy}, 32'd0);

    // accumulate form (or unused code)
    run_op(4'd5, 32'd0, 32'd0, dummy);
    run_op(4'd6, 32'hFFFFFFFF, 32'd0, dummy);
    run_op(4'd7, 32'd1, 32'd1, cyc);
`ifdef MDU_MADD_EN
    check("madd_cycles", 32'(cyc), 32'(MC));
    check("madd_hi", HI, 32'd1);
    check("madd_lo", LO, 32'd0);
`else
    check("op7_cycles", 32'(cyc), 32'd0);
    check("op7_hi", HI, 32'd0);
    check("op7_lo", LO, 32'hFFFFFFFF);
`endif

    // randomized ops against the model
    hl = {HI, LO};
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 9));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 17));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      model(rop, ra, rb, hl, ecyc);
      run_op(rop, ra, rb, cyc);
      check($sformatf("rnd%0d_op%0d_cycles", n, rop), 32'(cyc), 32'(ecyc));
      check($sformatf("rnd%0d_op%0d_hi", n, rop), HI, hl[63:32]);
      check($sformatf("rnd%0d_op%0d_lo", n, rop), LO, hl[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
